branch_predictor_gshare: RTL and testbench

- Parametrised successor to the pipeline's fixed branch predictor.
- Configurable pattern-history table (PHT) of saturating counters, indexed by PC alone (bimodal) or by PC XOR global history (gshare).
- Predicts at Fetch. Resolves at Memory, where a mispredict drives the PC redirect and the D/E/M flushes.
- Carries the lookup index down the pipeline, so updates hit the same entry that was read.

---
 rtl/branch_predictor_gshare.sv | 111 +++++++++++
 tb/tb_branch_predictor_gshare.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Bimodal/gshare branch predictor: PHT of saturating counters, combinational Fetch lookup, Memory-stage resolve and redirect.
// Optional resolved-branch/mispredict statistics are built only when BP_STATS_EN is defined.
module branch_predictor_gshare #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 10,
  parameter int CNT_W     = 2,
  parameter int GHR_W     = 8,
  parameter int PRED_MODE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc_f,
  output logic              o_pred_taken_f,
  output logic [IDX_W-1:0]  o_pred_idx_f,
  input  logic              i_valid_m,
  input  logic              i_branch_m,
  input  logic [IDX_W-1:0]  i_idx_m,
  input  logic              i_taken_m,
  input  logic              i_pred_m,
  input  logic [ADDR_W-1:0] i_fix_pc_m,
  output logic              o_mispredict,
  output logic [ADDR_W-1:0] o_redirect_pc,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_flush_m,
  output logic [31:0]       o_stat_branches,
  output logic [31:0]       o_stat_mispredicts
);

  localparam int PHT_N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

  logic [CNT_W-1:0] r_pht [PHT_N];
  logic [GHR_W-1:0] r_ghr;

  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_idx;
  logic             w_res;
  logic             w_mispredict;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_unused_pc;

  assign w_pc_idx    = i_pc_f[IDX_W+1:2];
  assign w_unused_pc = ^{i_pc_f[ADDR_W-1:IDX_W+2], i_pc_f[1:0]};
  assign w_idx       = w_pc_idx ^ ((PRED_MODE != 0) ? IDX_W'(r_ghr) : '0);

  assign o_pred_idx_f   = w_idx;
  assign o_pred_taken_f = r_pht[w_idx][CNT_W-1];

  // Resolve outputs are held quiet while reset is asserted.
  assign w_res         = i_valid_m & i_branch_m;
  assign w_mispredict  = i_rst_n & w_res & (i_taken_m ^ i_pred_m);
  assign o_mispredict  = w_mispredict;
  assign o_redirect_pc = w_mispredict ? i_fix_pc_m : '0;
  assign o_flush_d     = w_mispredict;
  assign o_flush_e     = w_mispredict;
  assign o_flush_m     = w_mispredict;

  always_comb begin
    w_cnt_cur  = r_pht[i_idx_m];
    w_cnt_next = w_cnt_cur;
    if (i_taken_m) begin
      if (w_cnt_cur != CNT_MAX) w_cnt_next = w_cnt_cur + CNT_W'(1);
    end else begin
      if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= CNT_INIT;
    end else if (w_res) begin
      r_pht[i_idx_m] <= w_cnt_next;
    end
  end

  // History is shifted only by resolved branches, so it is never speculative.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ghr <= '0;
    end else if (w_res) begin
      r_ghr <= GHR_W'({r_ghr, i_taken_m});
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_res && (r_stat_branches != '1))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign o_stat_branches    = r_stat_branches;
  assign o_stat_mispredicts = r_stat_mispredicts;
`else
  assign o_stat_branches    = '0;
  assign o_stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench for branch_predictor_gshare: a gshare and a bimodal instance share stimulus and are checked against a table-based model.
module tb_branch_predictor_gshare;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 10;
  localparam int CNT_W  = 2;
  localparam int GHR_W  = 8;
  localparam int PHT_N  = 1 << IDX_W;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int CHALF  = 1 << (CNT_W - 1);
  localparam logic [31:0] PC_A = 32'h0040_0010;

  typedef struct {
    bit          rstN;
    logic [31:0] pc;
    bit          valid;
    bit          branch;
    int          idxM;
    bit          taken;
    bit          pred;
    logic [31:0] fix;
  } stim_t;

  typedef struct {
    bit          predG;
    int          idxG;
    bit          predB;
    int          idxB;
    bit          misp;
    logic [31:0] redir;
    longint      statBr;
    longint      statMp;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;
  logic [ADDR_W-1:0] pcF;
  logic validM, branchM, takenM, predM;
  logic [IDX_W-1:0] idxM;
  logic [ADDR_W-1:0] fixPcM;

  logic predTakenG, predTakenB;
  logic [IDX_W-1:0] predIdxG, predIdxB;
  logic mispG, mispB, flushDG, flushEG, flushMG, flushDB, flushEB, flushMB;
  logic [ADDR_W-1:0] redirG, redirB;
  logic [31:0] statBrG, statMpG, statBrB, statMpB;

  int checks = 0;
  int errors = 0;

  exp_t expQ[$];

  int phtG[PHT_N];
  int phtB[PHT_N];
  int ghr;
  longint mStatBr, mStatMp;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .GHR_W(GHR_W), .PRED_MODE(1)) dutG (
    .i_clk(clk), .i_rst_n(rstN), .i_pc_f(pcF),
    .o_pred_taken_f(predTakenG), .o_pred_idx_f(predIdxG),
    .i_valid_m(validM), .i_branch_m(branchM), .i_idx_m(idxM),
    .i_taken_m(takenM), .i_pred_m(predM), .i_fix_pc_m(fixPcM),
    .o_mispredict(mispG), .o_redirect_pc(redirG),
    .o_flush_d(flushDG), .o_flush_e(flushEG), .o_flush_m(flushMG),
    .o_stat_branches(statBrG), .o_stat_mispredicts(statMpG)
  );

  branch_predictor_gshare #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .GHR_W(GHR_W), .PRED_MODE(0)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_pc_f(pcF),
    .o_pred_taken_f(predTakenB), .o_pred_idx_f(predIdxB),
    .i_valid_m(validM), .i_branch_m(branchM), .i_idx_m(idxM),
    .i_taken_m(takenM), .i_pred_m(predM), .i_fix_pc_m(fixPcM),
    .o_mispredict(mispB), .o_redirect_pc(redirB),
    .o_flush_d(flushDB), .o_flush_e(flushEB), .o_flush_m(flushMB),
    .o_stat_branches(statBrB), .o_stat_mispredicts(statMpB)
  );

  function automatic void modelReset();
    for (int i = 0; i < PHT_N; i++) begin
      phtG[i] = CHALF - 1;
      phtB[i] = CHALF - 1;
    end
    ghr     = 0;
    mStatBr = 0;
    mStatMp = 0;
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > CMAX) return CMAX;
    return v;
  endfunction

  // Expected outputs come from the pre-edge state; the table is then advanced as the coming edge would.
  function automatic exp_t modelStep(input stim_t s);
    exp_t e;
    bit   res;
    if (!s.rstN) modelReset();
    e.idxB  = int'(s.pc >> 2) % PHT_N;
    e.idxG  = e.idxB ^ ghr;
    e.predB = phtB[e.idxB] >= CHALF;
    e.predG = phtG[e.idxG] >= CHALF;
    res     = s.rstN && s.valid && s.branch;
    e.misp  = res && (s.taken != s.pred);
    e.redir = e.misp ? s.fix : 32'h0;
`ifdef BP_STATS_EN
    e.statBr = mStatBr;
    e.statMp = mStatMp;
`else
    e.statBr = 0;
    e.statMp = 0;
`endif
    if (res) begin
      phtG[s.idxM] = sat(phtG[s.idxM] + (s.taken ? 1 : -1));
      phtB[s.idxM] = sat(phtB[s.idxM] + (s.taken ? 1 : -1));
      ghr = ((ghr * 2) + int'(s.taken)) % (1 << GHR_W);
      if (mStatBr < 64'hFFFF_FFFF) mStatBr++;
      if (e.misp && mStatMp < 64'hFFFF_FFFF) mStatMp++;
    end
    return e;
  endfunction

  function automatic stim_t mk(input bit r, input logic [31:0] pc, input bit v, input bit b,
                               input int idx, input bit t, input bit p, input logic [31:0] fix);
    stim_t s;
    s.rstN = r; s.pc = pc; s.valid = v; s.branch = b;
    s.idxM = idx; s.taken = t; s.pred = p; s.fix = fix;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s, input bit midReset);
    @(posedge clk);
    #1;
    rstN    = s.rstN;
    pcF     = s.pc;
    validM  = s.valid;
    branchM = s.branch;
    idxM    = IDX_W'(s.idxM);
    takenM  = s.taken;
    predM   = s.pred;
    fixPcM  = s.fix;
    if (midReset) begin
      #2;
      rstN   = 1'b0;
      s.rstN = 1'b0;
    end
    expQ.push_back(modelStep(s));
  endtask

  task automatic cmp(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("g_pred_taken", longint'(predTakenG), longint'(e.predG));
    cmp("g_pred_idx",   longint'(predIdxG),   longint'(e.idxG));
    cmp("b_pred_taken", longint'(predTakenB), longint'(e.predB));
    cmp("b_pred_idx",   longint'(predIdxB),   longint'(e.idxB));
    cmp("mispredict",   longint'({mispG, mispB}), e.misp ? 64'd3 : 64'd0);
    cmp("flushes",      longint'({flushDG, flushEG, flushMG, flushDB, flushEB, flushMB}), e.misp ? 64'd63 : 64'd0);
    cmp("redirect_g",   longint'(redirG), longint'(e.redir));
    cmp("redirect_b",   longint'(redirB), longint'(e.redir));
    cmp("stat_br",      longint'(statBrG), e.statBr);
    cmp("stat_mp",      longint'(statMpG), e.statMp);
    cmp("stat_br_b",    longint'(statBrB), e.statBr);
    cmp("stat_mp_b",    longint'(statMpB), e.statMp);
  endtask

  // Monitor: consume one expectation per cycle, half a period after inputs settle.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    stim_t s;
    rstN = 1'b0; pcF = '0; validM = 0; branchM = 0; idxM = '0;
    takenM = 0; predM = 0; fixPcM = '0;
    modelReset();

    applyStimulus(mk(0, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(0, PC_A, 1, 1, 4, 1, 0, 32'h0040_0100), 0);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 0);
    repeat (3) applyStimulus(mk(1, PC_A, 1, 1, 4, 1, 1, 32'h0040_0100), 0);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(1, PC_A, 1, 1, 4, 1, 0, 32'h0040_0100), 0);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(0, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(1, PC_A, 1, 1, 0, 1, 1, 0), 0);
    applyStimulus(mk(1, PC_A, 1, 1, 0, 1, 1, 0), 0);
    applyStimulus(mk(1, PC_A, 1, 1, 0, 0, 0, 0), 0);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(1, PC_A, 0, 1, 4, 1, 0, 32'h0040_0100), 0);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(0, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(1, PC_A, 1, 1, 4, 1, 1, 0), 0);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 1);
    applyStimulus(mk(1, PC_A, 0, 0, 0, 0, 0, 0), 0);

    for (int n = 0; n < 1500; n++) begin
      s.rstN   = ($urandom_range(0, 199) != 0);
      s.pc     = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      s.valid  = ($urandom_range(0, 3) != 0);
      s.branch = ($urandom_range(0, 2) != 0);
      s.idxM   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, PHT_N - 1)) : int'($urandom_range(0, 40));
      s.taken  = $urandom_range(0, 1) != 0;
      s.pred   = $urandom_range(0, 1) != 0;
      s.fix    = $urandom & 32'hFFFF_FFFC;
      applyStimulus(s, $urandom_range(0, 299) == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
